// File: rtl/lineattr_writer_if.sv
// Sprite-row handshake and line-attribute buffer write port shared by the
// sprite fetcher (master) and lineattr_writer (slave).
interface lineattr_writer_if;
  logic       line_start;
  logic       spr_valid;
  logic       spr_ready;
  logic [7:0] spr_x;
  logic [7:0] spr_pattern;
  logic [1:0] spr_attr;
  logic       spr_zoom;
  logic       busy;
  logic [7:0] wr_idx;
  logic [1:0] wr_data;
  logic       wr_en;
  logic       collision;
  logic       coll_clr;

  modport master (
    output line_start, spr_valid, spr_x, spr_pattern, spr_attr, spr_zoom, coll_clr,
    input  spr_ready, busy, wr_idx, wr_data, wr_en, collision
  );

  modport slave (
    input  line_start, spr_valid, spr_x, spr_pattern, spr_attr, spr_zoom, coll_clr,
    output spr_ready, busy, wr_idx, wr_data, wr_en, collision
  );
endinterface

// File: rtl/lineattr_writer.sv
// Line-attribute renderer: clears the 256x2 attribute buffer each line, then
// serialises sprite rows into per-pixel writes (first writer wins, sticky collision).
// Define LINEATTR_ZOOM_EN to enable double-width sprites via spr_zoom.
module lineattr_writer (
  input  logic               clk,
  input  logic               reset,
  lineattr_writer_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_DRAW  = 2'd3;

  logic [1:0]   r_state;
  logic [8:0]   r_cnt;
  logic [7:0]   r_x;
  logic [7:0]   r_pat;
  logic [1:0]   r_attr;
  logic         r_zoom;
  logic [255:0] r_occ;
  logic         r_wr_en;
  logic [7:0]   r_wr_idx;
  logic [1:0]   r_wr_data;
  logic         r_coll;

  logic         w_zoom_in;
  logic         w_take;
  logic         w_draw_done;
  logic [7:0]   w_x;
  logic [7:0]   w_pat;
  logic [1:0]   w_attr;
  logic         w_zoom;
  logic [3:0]   w_pix;
  logic [2:0]   w_sel;
  logic         w_bit;
  logic [8:0]   w_pos;
  logic         w_occ;
  logic         w_pix_act;
  logic         w_wr;
  logic         w_hit;

`ifdef LINEATTR_ZOOM_EN
  assign w_zoom_in = bus.spr_zoom;
`else
  logic w_unused_zoom;
  assign w_unused_zoom = bus.spr_zoom;
  assign w_zoom_in     = 1'b0;
`endif

  assign w_take      = (r_state == S_READY) && bus.spr_valid;
  assign w_draw_done = (r_cnt == (r_zoom ? 9'd16 : 9'd8));

  // Pixel 0 is rendered straight from the request so its write lands at T+1.
  always_comb begin
    if (w_take) begin
      w_x    = bus.spr_x;
      w_pat  = bus.spr_pattern;
      w_attr = bus.spr_attr;
      w_zoom = w_zoom_in;
      w_pix  = 4'd0;
    end else begin
      w_x    = r_x;
      w_pat  = r_pat;
      w_attr = r_attr;
      w_zoom = r_zoom;
      w_pix  = r_cnt[3:0];
    end
  end

  assign w_sel     = w_zoom ? w_pix[3:1] : w_pix[2:0];
  assign w_bit     = w_pat[3'd7 - w_sel];
  assign w_pos     = {1'b0, w_x} + {5'd0, w_pix};
  assign w_occ     = r_occ[w_pos[7:0]];
  assign w_pix_act = w_take || ((r_state == S_DRAW) && !w_draw_done);
  assign w_wr      = w_pix_act && w_bit && !w_pos[8] && !w_occ;
  assign w_hit     = w_pix_act && w_bit && !w_pos[8] && w_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 9'd0;
      r_wr_en   <= 1'b0;
      r_wr_idx  <= 8'd0;
      r_wr_data <= 2'd0;
      r_coll    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_hit && !bus.line_start) begin
        r_coll <= 1'b1;
      end else if (bus.coll_clr) begin
        r_coll <= 1'b0;
      end

      if (bus.line_start) begin
        r_state   <= S_CLEAR;
        r_cnt     <= 9'd1;
        r_wr_en   <= 1'b1;
        r_wr_idx  <= 8'd0;
        r_wr_data <= 2'd0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (r_cnt[8]) begin
              r_state <= S_READY;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_idx  <= r_cnt[7:0];
              r_wr_data <= 2'd0;
              r_cnt     <= r_cnt + 9'd1;
            end
          end
          S_READY: begin
            if (bus.spr_valid) begin
              r_state <= S_DRAW;
              r_cnt   <= 9'd1;
            end
          end
          S_DRAW: begin
            if (w_draw_done) begin
              r_state <= S_READY;
            end else begin
              r_cnt <= r_cnt + 9'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_wr) begin
          r_wr_en   <= 1'b1;
          r_wr_idx  <= w_pos[7:0];
          r_wr_data <= w_attr;
        end
      end
    end
  end

  // Occupancy is only meaningful after a clear pass, which wipes it.
  always_ff @(posedge clk) begin
    if (bus.line_start) begin
      r_occ <= '0;
    end else if (w_wr) begin
      r_occ[w_pos[7:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_x    <= bus.spr_x;
      r_pat  <= bus.spr_pattern;
      r_attr <= bus.spr_attr;
      r_zoom <= w_zoom_in;
    end
  end

  assign bus.spr_ready = (r_state == S_READY);
  assign bus.busy      = (r_state == S_CLEAR) || (r_state == S_DRAW);
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_idx    = r_wr_idx;
  assign bus.wr_data   = r_wr_data;
  assign bus.collision = r_coll;
endmodule

// File: tb/tb_lineattr_writer.sv
// Directed bench for lineattr_writer: a per-cycle expectation timeline built
// from the line/sprite rules, compared every cycle, plus literal spot checks.
module tb_lineattr_writer;
  localparam int MAXC = 4000;

  logic clk;
  logic reset;
  lineattr_writer_if bus();

  lineattr_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic chk_on = 1'b0;

  logic       e_en   [MAXC];
  logic [7:0] e_idx  [MAXC];
  logic [1:0] e_dat  [MAXC];
  logic       e_busy [MAXC];
  logic       e_rdy  [MAXC];
  logic       e_set  [MAXC];
  logic       m_clr  [MAXC];
  logic [255:0] m_occ;
  logic       m_coll = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // New line at cycle L: 256 clear writes, then idle-ready forever after.
  function automatic void m_line(input int L);
    for (int c = L + 1; c < MAXC; c++) begin
      e_set[c] = 1'b0;
      if (c <= L + 256) begin
        e_en[c]   = 1'b1;
        e_idx[c]  = 8'(c - L - 1);
        e_dat[c]  = 2'd0;
        e_busy[c] = 1'b1;
        e_rdy[c]  = 1'b0;
      end else begin
        e_en[c]   = 1'b0;
        e_busy[c] = 1'b0;
        e_rdy[c]  = 1'b1;
      end
    end
    m_occ = '0;
  endfunction

  // Sprite accepted at cycle T: pixel i lands at T+1+i.
  function automatic void m_spr(input int T, input int x, input logic [7:0] pat,
                                input logic [1:0] a, input logic z);
    int n;
    logic zen;
`ifdef LINEATTR_ZOOM_EN
    zen = z;
`else
    zen = 1'b0;
    if (z) zen = 1'b0;
`endif
    n = zen ? 16 : 8;
    for (int c = T + 1; c < MAXC; c++) begin
      int i;
      int p;
      int b;
      i = c - T - 1;
      e_set[c] = 1'b0;
      e_en[c]  = 1'b0;
      if (i < n) begin
        e_busy[c] = 1'b1;
        e_rdy[c]  = 1'b0;
        p = x + i;
        b = zen ? 7 - i / 2 : 7 - i;
        if (pat[b] && p < 256) begin
          if (m_occ[p]) begin
            e_set[c] = 1'b1;
          end else begin
            m_occ[p]  = 1'b1;
            e_en[c]   = 1'b1;
            e_idx[c]  = 8'(p);
            e_dat[c]  = a;
          end
        end
      end else begin
        e_busy[c] = 1'b0;
        e_rdy[c]  = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      if (e_set[cyc]) m_coll = 1'b1;
      else if (cyc > 0 && m_clr[cyc-1]) m_coll = 1'b0;
      chk("wr_en", bus.wr_en, e_en[cyc]);
      chk("busy", bus.busy, e_busy[cyc]);
      chk("spr_ready", bus.spr_ready, e_rdy[cyc]);
      chk("collision", bus.collision, m_coll);
      if (e_en[cyc]) begin
        chk("wr_idx", bus.wr_idx, e_idx[cyc]);
        chk("wr_data", bus.wr_data, e_dat[cyc]);
      end
    end
  end

  task automatic line();
    bus.line_start = 1'b1;
    m_line(cyc);
    tick();
    bus.line_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] pat, input logic [1:0] a,
                      input logic z, input logic clr);
    bus.spr_valid   = 1'b1;
    bus.spr_x       = x;
    bus.spr_pattern = pat;
    bus.spr_attr    = a;
    bus.spr_zoom    = z;
    bus.coll_clr    = clr;
    m_clr[cyc]      = clr;
    m_spr(cyc, int'(x), pat, a, z);
    tick();
    bus.spr_valid = 1'b0;
    bus.coll_clr  = 1'b0;
  endtask

  task automatic clear_coll();
    bus.coll_clr = 1'b1;
    m_clr[cyc]   = 1'b1;
    tick();
    bus.coll_clr = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!bus.spr_ready && n < budget) begin
      tick();
      n++;
    end
    if (!bus.spr_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: spr_ready still 0 after %0d cycles, required 1", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      e_en[c] = 1'b0; e_idx[c] = 8'd0; e_dat[c] = 2'd0;
      e_busy[c] = 1'b0; e_rdy[c] = 1'b0; e_set[c] = 1'b0; m_clr[c] = 1'b0;
    end
    m_occ = '0;
    reset = 1'b1;
    bus.line_start = 1'b0; bus.spr_valid = 1'b0; bus.spr_x = 8'd0;
    bus.spr_pattern = 8'd0; bus.spr_attr = 2'd0; bus.spr_zoom = 1'b0; bus.coll_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", bus.spr_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_idx", bus.wr_idx, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_collision", bus.collision, 0);
    reset  = 1'b0;
    chk_on = 1'b1;
    tick();

    // request while IDLE must be ignored
    bus.spr_valid = 1'b1; bus.spr_x = 8'h10; bus.spr_pattern = 8'hFF; bus.spr_attr = 2'd1;
    tick();
    bus.spr_valid = 1'b0;
    tick(); tick();

    line();
    chk("clr_first_en", bus.wr_en, 1);
    chk("clr_first_idx", bus.wr_idx, 0);
    repeat (255) tick();
    chk("clr_last_idx", bus.wr_idx, 8'hFF);
    chk("clr_last_busy", bus.busy, 1);
    chk("clr_last_ready", bus.spr_ready, 0);
    tick();
    chk("clr_ready", bus.spr_ready, 1);
    chk("clr_done_busy", bus.busy, 0);

    send(8'h10, 8'hA5, 2'd2, 1'b0, 1'b0);
    chk("a5_p0_en", bus.wr_en, 1);
    chk("a5_p0_idx", bus.wr_idx, 8'h10);
    chk("a5_p0_data", bus.wr_data, 2);
    tick();
    chk("a5_p1_en", bus.wr_en, 0);
    repeat (6) tick();
    chk("a5_p7_idx", bus.wr_idx, 8'h17);
    tick();
    chk("a5_ready_t9", bus.spr_ready, 1);

    send(8'hFC, 8'hFF, 2'd1, 1'b0, 1'b0);
    chk("clip_p0_idx", bus.wr_idx, 8'hFC);
    repeat (4) tick();
    chk("clip_p4_en", bus.wr_en, 0);
    repeat (3) tick();
    chk("clip_t8_busy", bus.busy, 1);
    tick();
    chk("clip_ready_t9", bus.spr_ready, 1);

    send(8'h20, 8'hFF, 2'd1, 1'b0, 1'b0);
    wait_ready(40);
    send(8'h24, 8'hFF, 2'd3, 1'b0, 1'b1);
    chk("ovl_coll_set", bus.collision, 1);
    chk("ovl_p0_en", bus.wr_en, 0);
    repeat (4) tick();
    chk("ovl_p4_idx", bus.wr_idx, 8'h28);
    chk("ovl_p4_data", bus.wr_data, 3);
    wait_ready(40);
    clear_coll();
    chk("coll_cleared", bus.collision, 0);

    send(8'h50, 8'hF0, 2'd1, 1'b0, 1'b0);
    wait_ready(40);
    send(8'h52, 8'h3C, 2'd2, 1'b0, 1'b0);
    wait_ready(40);
    send(8'h4E, 8'hFF, 2'd3, 1'b0, 1'b0);
    wait_ready(40);
    clear_coll();
    tick();

    // line_start together with a request: the request is dropped
    bus.line_start = 1'b1; bus.spr_valid = 1'b1;
    bus.spr_x = 8'h60; bus.spr_pattern = 8'hFF; bus.spr_attr = 2'd1;
    m_line(cyc);
    tick();
    bus.line_start = 1'b0; bus.spr_valid = 1'b0;
    repeat (100) tick();
    line();
    chk("reclear_idx0", bus.wr_idx, 0);
    wait_ready(300);

    send(8'h30, 8'hFF, 2'd1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("abort_p3_idx", bus.wr_idx, 8'h33);
    line();
    chk("abort_clear_en", bus.wr_en, 1);
    chk("abort_clear_idx", bus.wr_idx, 0);
    wait_ready(300);
    send(8'h30, 8'hFF, 2'd2, 1'b0, 1'b0);
    wait_ready(40);
    chk("abort_no_coll", bus.collision, 0);

    send(8'h40, 8'h80, 2'd1, 1'b1, 1'b0);
    chk("zoom_p0_idx", bus.wr_idx, 8'h40);
    tick();
`ifdef LINEATTR_ZOOM_EN
    chk("zoom_p1_en", bus.wr_en, 1);
    chk("zoom_p1_idx", bus.wr_idx, 8'h41);
    repeat (14) tick();
    chk("zoom_t16_ready", bus.spr_ready, 0);
    tick();
    chk("zoom_t17_ready", bus.spr_ready, 1);
`else
    chk("nozoom_p1_en", bus.wr_en, 0);
    repeat (6) tick();
    chk("nozoom_t8_ready", bus.spr_ready, 0);
    tick();
    chk("nozoom_t9_ready", bus.spr_ready, 1);
`endif
    send(8'hFF, 8'hC0, 2'd2, 1'b1, 1'b0);
    wait_ready(40);
    repeat (3) tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
